// File: rtl/semaphore_read_controller.sv
// Read-back path of the semaphore block: per-core read requests are arbitrated
// round-robin, one grant per cycle, and the addressed 4-bit slot is returned with a 1-cycle ack.
module semaphore_read_controller #(
   parameter int NumberOfSemaphores = 4,
   parameter int NumberOfCores      = 2,
   localparam int SemIdxWidth = (NumberOfSemaphores > 1) ? $clog2(NumberOfSemaphores) : 1
) (
   input  logic                                      SEMAPHOREREADCONTROLLER_Clk,
   input  logic                                      SEMAPHOREREADCONTROLLER_nReset,
   input  logic [NumberOfCores-1:0]                  SEMAPHOREREADCONTROLLER_Rd_req,
   input  logic [NumberOfCores*SemIdxWidth-1:0]      SEMAPHOREREADCONTROLLER_Rd_addr,
   input  logic [4*NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREREADCONTROLLER_Data_fromSemaphore,
   output logic [4*NumberOfCores-1:0]                SEMAPHOREREADCONTROLLER_Data_toCPU,
   output logic [NumberOfCores-1:0]                  SEMAPHOREREADCONTROLLER_Rd_ack,
   output logic [NumberOfCores-1:0]                  SEMAPHOREREADCONTROLLER_Busy,
   output logic [NumberOfCores-1:0]                  SEMAPHOREREADCONTROLLER_Rd_overrun,
   output logic [2*NumberOfCores-1:0]                dbg_state
);

   localparam int NS = NumberOfSemaphores;
   localparam int NC = NumberOfCores;
   localparam int SW = SemIdxWidth;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;
   localparam bit AddrCanOverflow = ((1 << SW) != NS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Handshake: a Rd_req bit is a single-cycle request, accepted only while that core
   // is IDLE or DONE; Rd_ack is the one-cycle completion that presents Data_toCPU.
   // A request seen while WAIT is dropped and flagged on Rd_overrun the next cycle.

   logic [1:0]    state    [NC];
   logic [SW-1:0] lat_addr [NC];
   logic [3:0]    data_q   [NC];
   logic [3:0]    slot_arr [NC][NS];
   logic [3:0]    slot_word[NC];
   logic [NC-1:0] overrun_q;
   logic [NC-1:0] wait_vec;
   logic [NC-1:0] grant;
   logic          grant_vld;
   logic [CW-1:0] rr_ptr;
   logic [CW-1:0] next_ptr;

   always_comb begin
      for (int c = 0; c < NC; c++) begin
         for (int s = 0; s < NS; s++) begin
            slot_arr[c][s] = SEMAPHOREREADCONTROLLER_Data_fromSemaphore[4*(c*NS+s) +: 4];
         end
      end
   end

   // Indices beyond the populated slots read as zero.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         slot_word[c] = 4'b0000;
         if (!(AddrCanOverflow && (int'(lat_addr[c]) >= NS))) begin
            slot_word[c] = slot_arr[c][lat_addr[c]];
         end
      end
   end

   always_comb begin
      wait_vec = '0;
      for (int c = 0; c < NC; c++) begin
         wait_vec[c] = (state[c] == ST_WAIT);
      end
   end

   // Scan from rr_ptr upward (mod NC); the first waiting core wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      next_ptr  = rr_ptr;
      for (int i = 0; i < NC; i++) begin
         for (int c = 0; c < NC; c++) begin
            if (!grant_vld && wait_vec[c] && (((int'(rr_ptr) + i) % NC) == c)) begin
               grant[c]  = 1'b1;
               grant_vld = 1'b1;
               next_ptr  = CW'((c + 1) % NC);
            end
         end
      end
   end

   always_ff @(posedge SEMAPHOREREADCONTROLLER_Clk or negedge SEMAPHOREREADCONTROLLER_nReset) begin
      if (!SEMAPHOREREADCONTROLLER_nReset) begin
         rr_ptr    <= '0;
         overrun_q <= '0;
         for (int c = 0; c < NC; c++) begin
            state[c]    <= ST_IDLE;
            lat_addr[c] <= '0;
            data_q[c]   <= 4'b0000;
         end
      end else begin
         if (grant_vld) begin
            rr_ptr <= next_ptr;
         end
         for (int c = 0; c < NC; c++) begin
            overrun_q[c] <= SEMAPHOREREADCONTROLLER_Rd_req[c] && (state[c] == ST_WAIT);
            if (grant[c]) begin
               data_q[c] <= slot_word[c];
            end
            case (state[c])
               ST_IDLE, ST_DONE: begin
                  if (SEMAPHOREREADCONTROLLER_Rd_req[c]) begin
                     state[c]    <= ST_WAIT;
                     lat_addr[c] <= SEMAPHOREREADCONTROLLER_Rd_addr[c*SW +: SW];
                  end else begin
                     state[c] <= ST_IDLE;
                  end
               end
               ST_WAIT: begin
                  if (grant[c]) begin
                     state[c] <= ST_DONE;
                  end
               end
               default: state[c] <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      SEMAPHOREREADCONTROLLER_Data_toCPU  = '0;
      SEMAPHOREREADCONTROLLER_Rd_ack      = '0;
      SEMAPHOREREADCONTROLLER_Busy        = '0;
      SEMAPHOREREADCONTROLLER_Rd_overrun  = overrun_q;
      dbg_state                           = '0;
      for (int c = 0; c < NC; c++) begin
         SEMAPHOREREADCONTROLLER_Data_toCPU[4*c +: 4] = data_q[c];
         SEMAPHOREREADCONTROLLER_Rd_ack[c]            = (state[c] == ST_DONE);
         SEMAPHOREREADCONTROLLER_Busy[c]              = wait_vec[c];
         dbg_state[2*c +: 2]                          = state[c];
      end
   end

endmodule

// File: tb/tb_semaphore_read_controller.sv
// Bench for semaphore_read_controller (NS=4, NC=2): scenario tasks with inline timing
// checks, plus a per-core expected-data queue popped whenever Rd_ack is seen.
module tb_semaphore_read_controller;

   logic        clk;
   logic        rst_n;
   logic [1:0]  rd_req;
   logic [3:0]  rd_addr;
   logic [31:0] data_from_sem;
   logic [7:0]  data_to_cpu;
   logic [1:0]  rd_ack;
   logic [1:0]  busy;
   logic [1:0]  rd_overrun;
   logic [3:0]  dbg_state;

   logic [3:0]  slot [8];
   logic [3:0]  exp_q0[$];
   logic [3:0]  exp_q1[$];
   int          errors;
   int          checks;
   int          ack0_cnt;

   semaphore_read_controller #(
      .NumberOfSemaphores(4),
      .NumberOfCores(2)
   ) dut (
      .SEMAPHOREREADCONTROLLER_Clk(clk),
      .SEMAPHOREREADCONTROLLER_nReset(rst_n),
      .SEMAPHOREREADCONTROLLER_Rd_req(rd_req),
      .SEMAPHOREREADCONTROLLER_Rd_addr(rd_addr),
      .SEMAPHOREREADCONTROLLER_Data_fromSemaphore(data_from_sem),
      .SEMAPHOREREADCONTROLLER_Data_toCPU(data_to_cpu),
      .SEMAPHOREREADCONTROLLER_Rd_ack(rd_ack),
      .SEMAPHOREREADCONTROLLER_Busy(busy),
      .SEMAPHOREREADCONTROLLER_Rd_overrun(rd_overrun),
      .dbg_state(dbg_state)
   );

   // clock / slot array
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      data_from_sem = '0;
      for (int i = 0; i < 8; i++) data_from_sem[4*i +: 4] = slot[i];
   end

   // scoreboard: every ack must match the oldest expected value for that core
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_ack[0]) begin
            checks++;
            ack0_cnt++;
            if (exp_q0.size() == 0) begin
               errors++;
               $display("FAIL sb_core0: unexpected ack, data=%h", data_to_cpu[3:0]);
            end else begin
               logic [3:0] e0;
               e0 = exp_q0.pop_front();
               if (data_to_cpu[3:0] !== e0) begin
                  errors++;
                  $display("FAIL sb_core0: data=%h expected=%h", data_to_cpu[3:0], e0);
               end
            end
         end
         if (rd_ack[1]) begin
            checks++;
            if (exp_q1.size() == 0) begin
               errors++;
               $display("FAIL sb_core1: unexpected ack, data=%h", data_to_cpu[7:4]);
            end else begin
               logic [3:0] e1;
               e1 = exp_q1.pop_front();
               if (data_to_cpu[7:4] !== e1) begin
                  errors++;
                  $display("FAIL sb_core1: data=%h expected=%h", data_to_cpu[7:4], e1);
               end
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] req, input logic [1:0] a0, input logic [1:0] a1);
      rd_req  = req;
      rd_addr = {a1, a0};
   endtask

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_req(2'b00, 2'd0, 2'd0);
      #1;
      chk2("reset_busy", busy, 2'b00);
      chk2("reset_ack", rd_ack, 2'b00);
      chk2("reset_overrun", rd_overrun, 2'b00);
      checks++;
      if (data_to_cpu !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got=%h expected=00", data_to_cpu);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      slot[6] = 4'hA;
      set_req(2'b10, 2'd0, 2'd2);
      exp_q1.push_back(slot[6]);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      chk2("single_busy", busy, 2'b10);
      chk2("single_no_early_ack", rd_ack, 2'b00);
      chk2("single_state_wait", dbg_state[3:2], 2'd1);
      tick();
      chk2("single_ack", rd_ack, 2'b10);
      checks++;
      if (data_to_cpu[7:4] !== 4'hA) begin
         errors++;
         $display("FAIL single_data: got=%h expected=a", data_to_cpu[7:4]);
      end
      tick();
      chk2("single_ack_width", rd_ack, 2'b00);
   endtask

   task automatic test_contention();
      for (int r = 0; r < 2; r++) begin
         slot[0] = 4'(4'h3 + r);
         slot[5] = 4'(4'hC - r);
         set_req(2'b11, 2'd0, 2'd1);
         exp_q0.push_back(slot[0]);
         exp_q1.push_back(slot[5]);
         tick();
         set_req(2'b00, 2'd0, 2'd0);
         chk2("cont_busy_both", busy, 2'b11);
         tick();
         chk2("cont_first_core0", rd_ack, 2'b01);
         chk2("cont_core1_waits", busy, 2'b10);
         tick();
         chk2("cont_second_core1", rd_ack, 2'b10);
         tick();
      end
   endtask

   task automatic test_overrun();
      slot[1] = 4'h6;
      slot[2] = 4'h9;
      slot[7] = 4'hB;
      set_req(2'b01, 2'd1, 2'd0);
      exp_q0.push_back(slot[1]);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      tick();
      tick();
      // rr_ptr now points at core1, so core1 wins the next tie
      ack0_cnt = 0;
      set_req(2'b11, 2'd2, 2'd3);
      exp_q0.push_back(slot[2]);
      exp_q1.push_back(slot[7]);
      tick();
      set_req(2'b01, 2'd1, 2'd0);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      chk2("ovr_core1_first", rd_ack, 2'b10);
      chk2("ovr_pulse", rd_overrun, 2'b01);
      tick();
      chk2("ovr_core0_ack", rd_ack, 2'b01);
      chk2("ovr_pulse_width", rd_overrun, 2'b00);
      tick();
      tick();
      checks++;
      if (ack0_cnt != 1) begin
         errors++;
         $display("FAIL ovr_single_ack: acks=%0d expected=1", ack0_cnt);
      end
   endtask

   task automatic test_back_to_back();
      slot[0] = 4'h1;
      slot[1] = 4'h4;
      slot[2] = 4'h8;
      slot[3] = 4'hE;
      for (int i = 0; i < 4; i++) begin
         set_req(2'b01, 2'(i), 2'd0);
         exp_q0.push_back(slot[i]);
         tick();
         chk2("b2b_busy", busy, 2'b01);
         set_req(2'b01, 2'(3 - i), 2'd0);
         tick();
         chk2("b2b_ack", rd_ack, 2'b01);
         chk2("b2b_overrun", rd_overrun, 2'b01);
         checks++;
         if (data_to_cpu[3:0] !== slot[i]) begin
            errors++;
            $display("FAIL b2b_data: got=%h expected=%h", data_to_cpu[3:0], slot[i]);
         end
      end
      set_req(2'b00, 2'd0, 2'd0);
      tick();
      chk2("b2b_idle", rd_ack, 2'b00);
   endtask

   task automatic test_data_hold();
      for (int i = 0; i < 4; i++) slot[i] = 4'($urandom_range(0, 4) + 4'h2);
      slot[3] = 4'h5;
      for (int t = 0; t < 3; t++) begin
         tick();
         checks++;
         if (data_to_cpu[3:0] !== 4'hE) begin
            errors++;
            $display("FAIL hold_data: got=%h expected=e", data_to_cpu[3:0]);
         end
      end
      set_req(2'b01, 2'd3, 2'd0);
      exp_q0.push_back(slot[3]);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      tick();
      checks++;
      if (data_to_cpu[3:0] !== 4'h5) begin
         errors++;
         $display("FAIL hold_new_data: got=%h expected=5", data_to_cpu[3:0]);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      set_req(2'b01, 2'd0, 2'd0);
      exp_q0.push_back(slot[0]);
      tick();
      set_req(2'b00, 2'd0, 2'd0);
      chk2("rmid_busy_pre", busy, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q0.delete();
      exp_q1.delete();
      chk2("rmid_busy", busy, 2'b00);
      chk2("rmid_ack", rd_ack, 2'b00);
      chk2("rmid_overrun", rd_overrun, 2'b00);
      checks++;
      if (data_to_cpu !== 8'h00) begin
         errors++;
         $display("FAIL rmid_data: got=%h expected=00", data_to_cpu);
      end
      tick();
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         chk2("rmid_no_late_ack", rd_ack, 2'b00);
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      ack0_cnt = 0;
      for (int i = 0; i < 8; i++) slot[i] = 4'h0;
      test_reset();
      test_single();
      test_contention();
      test_overrun();
      test_back_to_back();
      test_data_hold();
      test_reset_mid();
      checks++;
      if ((exp_q0.size() + exp_q1.size()) != 0) begin
         errors++;
         $display("FAIL sb_drain: pending=%0d expected=0", exp_q0.size() + exp_q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
